// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset sequencer: one state per cycle (lw 5, sw 4, R/I 4, branch 3 cycles).
// Memory states stall on mem_ready; a bounded wait ends in a bus_error pulse and a return to FETCH.
module multicycle_control_fsm #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic [3:0] state,
   output logic       illegal_instr,
   output logic       bus_error
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_TRAP     = 4'd10;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   // Counter only needs to reach TIMEOUT_CYCLES-1; with no timeout it just saturates.
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic          TO_EN   = (TIMEOUT_CYCLES != 0);

   logic [3:0]    cur_state;
   logic [3:0]    next_state;
   logic [CW-1:0] wait_cnt;
   logic          mem_state;
   logic          timeout_hit;
   logic          branch_taken;
   logic          branch_legal;
   logic [2:0]    exec_alu;
   logic [1:0]    dec_imm;

   assign mem_state   = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                        (cur_state == S_MEMWRITE);
   assign timeout_hit = TO_EN && mem_state && !mem_ready && (wait_cnt == TO_LAST);

   always_comb begin
      branch_taken = 1'b0;
      branch_legal = 1'b1;
      case (funct3)
         3'b000:  branch_taken = zero;
         3'b001:  branch_taken = ~zero;
         3'b100:  branch_taken = sign;
         default: branch_legal = 1'b0;
      endcase
   end

   always_comb begin
      exec_alu = ALU_ADD;
      case (funct3)
         3'b000:  exec_alu = (opcode[5] && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  exec_alu = ALU_SLL;
         3'b100:  exec_alu = ALU_XOR;
         3'b101:  exec_alu = ALU_SRL;
         3'b110:  exec_alu = ALU_OR;
         3'b111:  exec_alu = ALU_AND;
         default: exec_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      dec_imm = 2'b00;
      if (opcode == OP_SW)
         dec_imm = 2'b01;
      else if (opcode == OP_BR)
         dec_imm = 2'b10;
   end

   always_comb begin
      next_state = S_FETCH;
      case (cur_state)
         S_FETCH: begin
            if (timeout_hit)
               next_state = S_FETCH;
            else if (mem_ready)
               next_state = S_DECODE;
            else
               next_state = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXECR;
               OP_I:         next_state = S_EXECI;
               OP_BR:        next_state = branch_legal ? S_BRANCH : S_TRAP;
               default:      next_state = S_TRAP;
            endcase
         end
         S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            if (timeout_hit)
               next_state = S_FETCH;
            else if (mem_ready)
               next_state = S_MEMWB;
            else
               next_state = S_MEMREAD;
         end
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: next_state = (mem_ready || timeout_hit) ? S_FETCH : S_MEMWRITE;
         S_EXECR:    next_state = S_ALUWB;
         S_EXECI:    next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_BRANCH:   next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_FETCH;
         wait_cnt  <= '0;
      end else begin
         cur_state <= next_state;
         if (!mem_state || mem_ready || timeout_hit || (next_state != cur_state))
            wait_cnt <= '0;
         else if (wait_cnt != {CW{1'b1}})
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // Reset masks every output so an aborted instruction issues no enables in the rst cycle.
   always_comb begin
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      imm_src       = 2'b00;
      alu_control   = ALU_ADD;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      bus_error     = timeout_hit;
      state         = cur_state;
      case (cur_state)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = dec_imm;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = dec_imm;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = ~timeout_hit;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = exec_alu;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = exec_alu;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_write    = branch_taken;
         end
         default: begin
            illegal_instr = 1'b1;
         end
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         adr_src       = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         result_src    = 2'b00;
         alu_src_a     = 2'b00;
         alu_src_b     = 2'b00;
         imm_src       = 2'b00;
         alu_control   = 3'b000;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
         bus_error     = 1'b0;
         state         = 4'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with TIMEOUT_CYCLES=4.
// Inputs change 2 time units after each rising edge; outputs are sampled 1 unit later.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       sign;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       reg_write;
   logic [3:0] state;
   logic       illegal_instr;
   logic       bus_error;
   logic [17:0] outs;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .sign(sign), .mem_ready(mem_ready), .pc_write(pc_write),
      .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_control(alu_control), .reg_write(reg_write),
      .state(state), .illegal_instr(illegal_instr), .bus_error(bus_error)
   );

   assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  imm_src, alu_control, reg_write, illegal_instr, bus_error};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
   endtask

   // Entered in a FETCH cycle; leaves in the FETCH cycle that follows ALUWB.
   task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] exp_st, input logic [1:0] exp_b,
                          input logic [2:0] exp_alu);
      set_instr(op, f3, f7);
      mem_ready = 1'b1;
      #1;
      chk({tag, "_fetch_state"}, 32'(state), 32'd0);
      chk({tag, "_fetch_irw"}, 32'(ir_write), 32'd1);
      chk({tag, "_fetch_srcb"}, 32'(alu_src_b), 32'd2);
      next_cycle(); #1;
      chk({tag, "_decode_state"}, 32'(state), 32'd1);
      next_cycle(); #1;
      chk({tag, "_exec_state"}, 32'(state), 32'(exp_st));
      chk({tag, "_exec_alu"}, 32'(alu_control), 32'(exp_alu));
      chk({tag, "_exec_srcb"}, 32'(alu_src_b), 32'(exp_b));
      chk({tag, "_exec_regw"}, 32'(reg_write), 32'd0);
      next_cycle(); #1;
      chk({tag, "_aluwb_state"}, 32'(state), 32'd8);
      chk({tag, "_aluwb_regw"}, 32'(reg_write), 32'd1);
      next_cycle(); #1;
      chk({tag, "_back_fetch"}, 32'(state), 32'd0);
   endtask

   task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic s, input logic exp_pc);
      set_instr(OP_BR, f3, 1'b0);
      zero = z; sign = s; mem_ready = 1'b1;
      next_cycle(); #1;
      chk({tag, "_decode_imm"}, 32'(imm_src), 32'd2);
      next_cycle(); #1;
      chk({tag, "_br_state"}, 32'(state), 32'd9);
      chk({tag, "_br_alu"}, 32'(alu_control), 32'd2);
      chk({tag, "_br_pcw"}, 32'(pc_write), 32'(exp_pc));
      next_cycle(); #1;
      chk({tag, "_back_fetch"}, 32'(state), 32'd0);
   endtask

   task automatic run_trap(input string tag, input logic [6:0] op, input logic [2:0] f3);
      set_instr(op, f3, 1'b0);
      mem_ready = 1'b1;
      next_cycle(); #1;
      chk({tag, "_decode_state"}, 32'(state), 32'd1);
      next_cycle(); #1;
      chk({tag, "_trap_state"}, 32'(state), 32'd10);
      chk({tag, "_trap_illegal"}, 32'(illegal_instr), 32'd1);
      chk({tag, "_trap_pcw"}, 32'(pc_write), 32'd0);
      next_cycle(); #1;
      chk({tag, "_after_state"}, 32'(state), 32'd0);
      chk({tag, "_after_illegal"}, 32'(illegal_instr), 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      set_instr(OP_I, 3'b000, 1'b1);
      zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;

      // Reset: everything forced to 0 even though FETCH with mem_ready=1 would drive enables.
      next_cycle(); #1;
      chk("rst1_state", 32'(state), 32'd0);
      chk("rst1_outs", 32'(outs), 32'd0);
      next_cycle(); #1;
      chk("rst2_state", 32'(state), 32'd0);
      chk("rst2_outs", 32'(outs), 32'd0);
      rst = 1'b0;

      run_alu("addi", OP_I, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000);
      run_alu("sub",  OP_R, 3'b000, 1'b1, 4'd6, 2'b00, 3'b010);
      run_alu("srl",  OP_R, 3'b101, 1'b0, 4'd6, 2'b00, 3'b101);
      run_alu("and",  OP_R, 3'b111, 1'b0, 4'd6, 2'b00, 3'b111);

      // lw with three stalled cycles in MEMREAD
      set_instr(OP_LW, 3'b010, 1'b0);
      mem_ready = 1'b1;
      next_cycle(); #1;
      chk("lw_decode_imm", 32'(imm_src), 32'd0);
      next_cycle(); #1;
      chk("lw_memadr_state", 32'(state), 32'd2);
      chk("lw_memadr_srca", 32'(alu_src_a), 32'd2);
      chk("lw_memadr_srcb", 32'(alu_src_b), 32'd1);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mem_ready = (i == 3);
         #1;
         chk("lw_memread_state", 32'(state), 32'd3);
         chk("lw_memread_adr", 32'(adr_src), 32'd1);
         chk("lw_memread_buserr", 32'(bus_error), 32'd0);
      end
      next_cycle(); #1;
      chk("lw_memwb_state", 32'(state), 32'd4);
      chk("lw_memwb_rsrc", 32'(result_src), 32'd1);
      chk("lw_memwb_regw", 32'(reg_write), 32'd1);
      next_cycle(); #1;
      chk("lw_back_fetch", 32'(state), 32'd0);

      // sw holding mem_write for two stalled cycles
      set_instr(OP_SW, 3'b010, 1'b0);
      next_cycle(); #1;
      chk("sw_decode_imm", 32'(imm_src), 32'd1);
      next_cycle(); #1;
      chk("sw_memadr_imm", 32'(imm_src), 32'd1);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mem_ready = (i == 2);
         #1;
         chk("sw_memwrite_state", 32'(state), 32'd5);
         chk("sw_memwrite_wr", 32'(mem_write), 32'd1);
      end
      next_cycle(); #1;
      chk("sw_back_fetch", 32'(state), 32'd0);
      chk("sw_fetch_nowr", 32'(mem_write), 32'd0);

      run_branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1);
      run_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
      run_branch("blt_s1", 3'b100, 1'b0, 1'b1, 1'b1);
      zero = 1'b0; sign = 1'b0;
      run_trap("br_f3_010", OP_BR, 3'b010);
      run_trap("op_7f", 7'b1111111, 3'b000);

      // Unlisted encoding 12 behaves as TRAP
      force dut.cur_state = 4'd12;
      #1;
      chk("st12_state", 32'(state), 32'd12);
      chk("st12_illegal", 32'(illegal_instr), 32'd1);
      chk("st12_pcw", 32'(pc_write), 32'd0);
      release dut.cur_state;
      next_cycle(); #1;
      chk("st12_next_fetch", 32'(state), 32'd0);

      // FETCH timeout: bus_error on the 4th waiting cycle
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) next_cycle();
         #1;
         chk("to_state", 32'(state), 32'd0);
         chk("to_irw", 32'(ir_write), 32'd0);
         chk("to_buserr", 32'(bus_error), 32'(i == 3));
      end
      next_cycle(); #1;
      chk("to_after_state", 32'(state), 32'd0);
      chk("to_after_buserr", 32'(bus_error), 32'd0);

      // Reset during MEMWRITE suppresses the write and returns to FETCH
      set_instr(OP_SW, 3'b010, 1'b0);
      mem_ready = 1'b1;
      next_cycle(); next_cycle(); next_cycle();
      mem_ready = 1'b0;
      #1;
      chk("rstmw_state", 32'(state), 32'd5);
      chk("rstmw_wr_before", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmw_wr_in_rst", 32'(mem_write), 32'd0);
      chk("rstmw_outs_in_rst", 32'(outs), 32'd0);
      next_cycle();
      rst = 1'b0;
      #1;
      chk("rstmw_fetch", 32'(state), 32'd0);
      chk("rstmw_wr_after", 32'(mem_write), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
